megarom_bank_mapper: RTL and testbench

Parametrised bank-register and mode-register engine for MEGA ROM cartridges. It generalises the fixed four-bank, SCC-only mapper to 2–8 banks of 8 KiB, with these additions:
- per-bank address-decoded bank registers and write-edge qualification;
- an SCC/SCC-I mode register with per-bank lock and RAM-write control;
- a registered sound-window decode and a registered mapped-address output.

It sits between the cartridge bus front-end and the RAM/flash controller and SCC core inside a cartridge module.

---
 rtl/megarom_bank_mapper_if.sv | 15 +
 rtl/megarom_bank_mapper.sv | 222 ++++++++++++++++++++++
 tb/tb_megarom_bank_mapper.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/megarom_bank_mapper_if.sv
// Cartridge bus bundle between the slot front-end and the MEGA ROM bank mapper.
// The master drives strobes, address and write data; the slave returns readback data.
`timescale 1ns/1ps
interface megarom_bank_mapper_if;
  logic        SLTSL_n;
  logic        RD_n;
  logic        WR_n;
  logic [15:0] ADDR;
  logic [7:0]  DIN;
  logic [7:0]  DOUT;
  logic        BUSDIR_n;

  modport master (output SLTSL_n, RD_n, WR_n, ADDR, DIN, input DOUT, BUSDIR_n);
  modport slave  (input SLTSL_n, RD_n, WR_n, ADDR, DIN, output DOUT, BUSDIR_n);
endinterface

// File: rtl/megarom_bank_mapper.sv
// MEGA ROM bank/mode register engine with registered sound-window and mapped-address decode.
// Optional register readback is enabled by defining MEGAROM_MAPPER_READBACK_EN.
`timescale 1ns/1ps
module megarom_bank_mapper #(
  parameter int          BANK_COUNT      = 4,
  parameter logic [63:0] BANK_INIT       = 64'h0706050403020100,
  parameter logic [15:0] REG_ADDR_BASE   = 16'h5000,
  parameter logic [15:0] REG_ADDR_STRIDE = 16'h2000,
  parameter logic [15:0] REG_ADDR_MASK   = 16'hF800,
  parameter logic [7:0]  BANK_MASK       = 8'hFF,
  parameter logic [15:0] MODE_ADDR       = 16'hBFFE
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic                    BUS_RESET_n,
  input  logic                    SCC_I_ENA,
  megarom_bank_mapper_if.slave    bus,
  output logic [BANK_COUNT*8-1:0] BANK,
  output logic [BANK_COUNT-1:0]   RAM_WE,
  output logic                    SCC_I,
  output logic                    SOUND_SEL,
  output logic [20:0]             MAP_ADDR,
  output logic                    IN_WINDOW
);
  localparam int          IDX_W   = (BANK_COUNT > 4) ? 3 : ((BANK_COUNT > 2) ? 2 : 1);
  localparam logic [16:0] WIN_END = 17'h04000 + 17'(BANK_COUNT) * 17'h02000;

  logic [7:0]            bank_r [BANK_COUNT];
  logic [5:0]            mode_r;
  logic                  wr_n_prev_r;
  logic                  evt_r;
  logic [15:0]           evt_addr_r;
  logic [7:0]            evt_din_r;
  logic                  sound_r;
  logic [20:0]           map_r;
  logic                  win_r;
  logic [7:0]            dout_r;
  logic                  busdir_n_r;

  logic                  srst_s;
  logic                  wr_evt_s;
  logic                  mode_hit_s;
  logic [7:0]            prev_p_s;
  logic [BANK_COUNT-1:0] lock_s;
  logic [BANK_COUNT-1:0] wr_sel_s;
  logic [15:0]           off_s;
  logic [IDX_W-1:0]      k_s;
  logic [7:0]            cur_bank_s;
  logic                  in_win_s;
  logic                  sound_s;

  function automatic logic reg_match(input logic [15:0] a, input int i);
    logic [15:0] reg_addr;
    reg_addr = 16'(REG_ADDR_BASE + i * REG_ADDR_STRIDE);
    return ((a ^ reg_addr) & REG_ADDR_MASK) == 16'h0000;
  endfunction

  assign srst_s     = ~BUS_RESET_n;
  assign wr_evt_s   = ~bus.SLTSL_n & ~bus.WR_n & wr_n_prev_r;
  assign mode_hit_s = (evt_addr_r[15:1] == MODE_ADDR[15:1]) & SCC_I_ENA;
  // Bank i (1..3) is also locked by p(i-1); padded to 8 so every index is legal
  assign prev_p_s   = {4'b0000, mode_r[2:0], 1'b0};

  // Lock vector, bank write select (lowest unlocked match) and output flattening
  always_comb begin
    lock_s   = '0;
    wr_sel_s = '0;
    BANK     = '0;
    for (int i = 0; i < BANK_COUNT; i++) begin
      lock_s[i]       = mode_r[4] | prev_p_s[i];
      BANK[i*8 +: 8]  = bank_r[i];
    end
    if (evt_r && !mode_hit_s) begin
      for (int i = BANK_COUNT - 1; i >= 0; i--) begin
        if (reg_match(evt_addr_r, i) && !lock_s[i]) begin
          wr_sel_s    = '0;
          wr_sel_s[i] = 1'b1;
        end else begin
          wr_sel_s = wr_sel_s;
        end
      end
    end else begin
      wr_sel_s = '0;
    end
  end

  assign RAM_WE = lock_s;
  assign SCC_I  = mode_r[5];

  // Access decode for the current bus address
  always_comb begin
    off_s      = bus.ADDR - 16'h4000;
    k_s        = off_s[13 +: IDX_W];
    cur_bank_s = bank_r[k_s];
    in_win_s   = (bus.ADDR >= 16'h4000) && ({1'b0, bus.ADDR} < WIN_END);
    if (mode_r[5]) begin
      sound_s = (bus.ADDR[15:8] == 8'hB8) && cur_bank_s[7];
    end else begin
      sound_s = (bus.ADDR[15:8] == 8'h98) && (cur_bank_s[5:0] == 6'h3F);
    end
  end

  // Previous WR_n keeps tracking through slot reset so a held strobe cannot retrigger
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) wr_n_prev_r <= 1'b1;
    else          wr_n_prev_r <= bus.WR_n;
  end

  // Write event capture stage
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      evt_r      <= 1'b0;
      evt_addr_r <= 16'h0000;
      evt_din_r  <= 8'h00;
    end else if (srst_s) begin
      evt_r      <= 1'b0;
      evt_addr_r <= 16'h0000;
      evt_din_r  <= 8'h00;
    end else begin
      evt_r <= wr_evt_s;
      if (wr_evt_s) begin
        evt_addr_r <= bus.ADDR;
        evt_din_r  <= bus.DIN;
      end
    end
  end

  // Bank registers
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n || srst_s) begin
      for (int i = 0; i < BANK_COUNT; i++) bank_r[i] <= BANK_INIT[i*8 +: 8];
    end else begin
      for (int i = 0; i < BANK_COUNT; i++) begin
        if (wr_sel_s[i]) bank_r[i] <= evt_din_r & BANK_MASK;
      end
    end
  end

  // Mode register, held clear while SCC-I is not enabled
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)                     mode_r <= 6'h00;
    else if (srst_s || !SCC_I_ENA)    mode_r <= 6'h00;
    else if (evt_r && mode_hit_s)     mode_r <= evt_din_r[5:0];
  end

  // Registered access outputs
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sound_r <= 1'b0;
      map_r   <= 21'h000000;
      win_r   <= 1'b0;
    end else if (srst_s) begin
      sound_r <= 1'b0;
      map_r   <= 21'h000000;
      win_r   <= 1'b0;
    end else begin
      sound_r <= in_win_s & ~bus.SLTSL_n & sound_s;
      map_r   <= {cur_bank_s, bus.ADDR[12:0]};
      win_r   <= in_win_s;
    end
  end

  assign SOUND_SEL = sound_r;
  assign MAP_ADDR  = map_r;
  assign IN_WINDOW = win_r;

`ifdef MEGAROM_MAPPER_READBACK_EN
  logic       rd_hit_s;
  logic [7:0] rd_data_s;

  // Readback decode; mode address first, then lowest matching bank register
  always_comb begin
    rd_hit_s  = 1'b0;
    rd_data_s = 8'h00;
    if (!bus.SLTSL_n && !bus.RD_n) begin
      if (bus.ADDR[15:1] == MODE_ADDR[15:1]) begin
        rd_hit_s  = 1'b1;
        rd_data_s = {2'b00, mode_r};
      end else begin
        for (int i = BANK_COUNT - 1; i >= 0; i--) begin
          if (reg_match(bus.ADDR, i)) begin
            rd_hit_s  = 1'b1;
            rd_data_s = bank_r[i];
          end else begin
            rd_hit_s = rd_hit_s;
          end
        end
      end
    end else begin
      rd_hit_s = 1'b0;
    end
  end

  // Registered readback driver
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      dout_r     <= 8'h00;
      busdir_n_r <= 1'b1;
    end else if (srst_s) begin
      dout_r     <= 8'h00;
      busdir_n_r <= 1'b1;
    end else begin
      dout_r     <= rd_hit_s ? rd_data_s : 8'h00;
      busdir_n_r <= ~rd_hit_s;
    end
  end
`else
  // Readback disabled: the bus is never driven
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      dout_r     <= 8'h00;
      busdir_n_r <= 1'b1;
    end else begin
      dout_r     <= 8'h00;
      busdir_n_r <= 1'b1;
    end
  end
`endif

  assign bus.DOUT     = dout_r;
  assign bus.BUSDIR_n = busdir_n_r;
endmodule

// File: tb/tb_megarom_bank_mapper.sv
// Scoreboard bench for megarom_bank_mapper: a 4-bank instance for mapping/locking and an
// 8-bank instance on the same bus for the upper-bank register and readback behaviour.
`timescale 1ns/1ps
module tb_megarom_bank_mapper;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET_n, BUS_RESET_n, SCC_I_ENA;
  megarom_bank_mapper_if bus4();
  megarom_bank_mapper_if bus8();

  assign bus8.SLTSL_n = bus4.SLTSL_n;
  assign bus8.RD_n    = bus4.RD_n;
  assign bus8.WR_n    = bus4.WR_n;
  assign bus8.ADDR    = bus4.ADDR;
  assign bus8.DIN     = bus4.DIN;

  logic [31:0] bank4;  logic [3:0] ram_we4; logic scc_i4, sound4, win4; logic [20:0] map4;
  logic [63:0] bank8;  logic [7:0] ram_we8; logic scc_i8, sound8, win8; logic [20:0] map8;

  megarom_bank_mapper #(.BANK_COUNT(4)) dut4 (
    .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n), .SCC_I_ENA(SCC_I_ENA),
    .bus(bus4.slave), .BANK(bank4), .RAM_WE(ram_we4), .SCC_I(scc_i4),
    .SOUND_SEL(sound4), .MAP_ADDR(map4), .IN_WINDOW(win4));

  megarom_bank_mapper #(.BANK_COUNT(8)) dut8 (
    .CLK(CLK), .RESET_n(RESET_n), .BUS_RESET_n(BUS_RESET_n), .SCC_I_ENA(SCC_I_ENA),
    .bus(bus8.slave), .BANK(bank8), .RAM_WE(ram_we8), .SCC_I(scc_i8),
    .SOUND_SEL(sound8), .MAP_ADDR(map8), .IN_WINDOW(win8));

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the 4-bank instance
  logic [7:0] m_bank [4];
  logic [5:0] m_mode;

  typedef struct packed {
    logic [15:0] addr;
    logic        snd;
    logic        win;
    logic [20:0] map;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic m_locked(input int i);
    logic p;
    if (i == 1)      p = m_mode[0];
    else if (i == 2) p = m_mode[1];
    else if (i == 3) p = m_mode[2];
    else             p = 1'b0;
    return m_mode[4] | p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = 8'(i);
    m_mode = 6'h00;
  endtask

  task automatic model_write(input logic [15:0] addr, input logic [7:0] data);
    logic [15:0] ra;
    if (addr[15:1] == 15'h5FFF && SCC_I_ENA) begin
      m_mode = data[5:0];
    end else begin
      for (int i = 0; i < 4; i++) begin
        ra = 16'h5000 + 16'(i) * 16'h2000;
        if ((((addr ^ ra) & 16'hF800) == 16'h0000) && !m_locked(i)) begin
          m_bank[i] = data;
          break;
        end
      end
    end
  endtask

  function automatic exp_t model_access(input logic [15:0] addr, input logic sl_n);
    exp_t e;
    logic [15:0] off;
    logic [7:0]  b;
    off    = addr - 16'h4000;
    b      = m_bank[off[14:13]];
    e.addr = addr;
    e.win  = (addr >= 16'h4000) && (addr < 16'hC000);
    e.map  = {b, addr[12:0]};
    if (m_mode[5]) e.snd = e.win && !sl_n && (addr[15:8] == 8'hB8) && b[7];
    else           e.snd = e.win && !sl_n && (addr[15:8] == 8'h98) && (b[5:0] == 6'h3F);
    return e;
  endfunction

  task automatic bus_idle();
    bus4.SLTSL_n = 1'b1; bus4.RD_n = 1'b1; bus4.WR_n = 1'b1;
    bus4.ADDR = 16'h0000; bus4.DIN = 8'h00;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    @(posedge CLK); #1;
    bus4.SLTSL_n = 1'b0; bus4.ADDR = addr; bus4.DIN = data; bus4.WR_n = 1'b0;
    repeat (hold) @(posedge CLK);
    #1;
    bus4.WR_n = 1'b1; bus4.SLTSL_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    model_write(addr, data);
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; BUS_RESET_n = 1'b1; SCC_I_ENA = 1'b1;
    bus_idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if (bank4 !== 32'h03020100) begin tests_failed++; $display("FAIL reset_bank4: got %h want %h", bank4, 32'h03020100); end
    tests_run++;
    if (bank8 !== 64'h0706050403020100) begin tests_failed++; $display("FAIL reset_bank8: got %h want %h", bank8, 64'h0706050403020100); end
    tests_run++;
    if ({ram_we4, scc_i4, sound4, win4} !== 7'b0) begin tests_failed++; $display("FAIL reset_flags: got %b want 0", {ram_we4, scc_i4, sound4, win4}); end
    tests_run++;
    if (map4 !== 21'h0) begin tests_failed++; $display("FAIL reset_map: got %h want 0", map4); end
    tests_run++;
    if ({bus4.BUSDIR_n, bus4.DOUT} !== 9'h100) begin tests_failed++; $display("FAIL reset_bus: got %h want 100", {bus4.BUSDIR_n, bus4.DOUT}); end
    RESET_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_sound_select();
    logic [15:0] acc_addr [10];
    logic        acc_sl   [10];
    exp_t        e;
    acc_addr = '{16'h9800, 16'h98FF, 16'h9900, 16'h9800, 16'h4000,
                 16'h3FFF, 16'hBFFF, 16'hC000, 16'hB800, 16'hB8FF};
    acc_sl   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0:       bus_write(16'h9000, 8'h3F, 2);
        1:       bus_write(16'h9000, 8'h3E, 2);
        default: begin bus_write(16'hBFFE, 8'h20, 2); bus_write(16'hB000, 8'h80, 2); end
      endcase
      tests_run++;
      if (bank4[23:16] !== m_bank[2]) begin tests_failed++; $display("FAIL sound_bank2 ph%0d: got %h want %h", ph, bank4[23:16], m_bank[2]); end
      for (int i = 0; i <= 10; i++) begin
        @(posedge CLK); #1;
        if (i > 0) begin
          e = sb_q.pop_front();
          tests_run++;
          if ({sound4, win4, map4} !== {e.snd, e.win, e.map}) begin
            tests_failed++;
            $display("FAIL access ph%0d addr %h: got snd=%b win=%b map=%h want snd=%b win=%b map=%h",
                     ph, e.addr, sound4, win4, map4, e.snd, e.win, e.map);
          end
        end
        if (i < 10) begin
          bus4.ADDR = acc_addr[i]; bus4.SLTSL_n = acc_sl[i];
          sb_q.push_back(model_access(acc_addr[i], acc_sl[i]));
        end else begin
          bus4.SLTSL_n = 1'b1;
        end
      end
    end
  endtask

  task automatic test_lock();
    bus_write(16'hBFFE, 8'h30, 2);
    tests_run++;
    if ({scc_i4, ram_we4} !== 5'b1_1111) begin tests_failed++; $display("FAIL lock_set: got %b want 11111", {scc_i4, ram_we4}); end
    bus_write(16'h5000, 8'h12, 2);
    tests_run++;
    if (bank4[7:0] !== 8'h00) begin tests_failed++; $display("FAIL lock_frozen: got %h want 00", bank4[7:0]); end
    bus_write(16'hBFFF, 8'h00, 2);
    tests_run++;
    if ({scc_i4, ram_we4} !== 5'b0) begin tests_failed++; $display("FAIL lock_clear: got %b want 0", {scc_i4, ram_we4}); end
    bus_write(16'h5000, 8'h12, 2);
    tests_run++;
    if (bank4[7:0] !== 8'h12) begin tests_failed++; $display("FAIL unlock_write: got %h want 12", bank4[7:0]); end
  endtask

  task automatic test_partial_lock();
    bus_write(16'hBFFE, 8'h05, 2);
    tests_run++;
    if ({scc_i4, ram_we4} !== 5'b0_1010) begin tests_failed++; $display("FAIL plock_ram_we: got %b want 01010", {scc_i4, ram_we4}); end
    tests_run++;
    if (ram_we8 !== 8'h0A) begin tests_failed++; $display("FAIL plock_ram_we8: got %h want 0a", ram_we8); end
    bus_write(16'h7000, 8'h09, 2);
    bus_write(16'h9000, 8'h09, 2);
    bus_write(16'h5000, 8'h44, 2);
    bus_write(16'hB000, 8'h7E, 2);
    tests_run++;
    if (bank4 !== 32'h80090144) begin tests_failed++; $display("FAIL plock_banks: got %h want 80090144", bank4); end
    bus_write(16'hBFFE, 8'h00, 2);
  endtask

  task automatic test_scc_enable();
    SCC_I_ENA = 1'b0;
    bus_write(16'hBFFE, 8'h30, 2);
    tests_run++;
    if ({scc_i4, ram_we4} !== 5'b0) begin tests_failed++; $display("FAIL ena_off_write: got %b want 0", {scc_i4, ram_we4}); end
    SCC_I_ENA = 1'b1;
    bus_write(16'hBFFE, 8'h20, 2);
    tests_run++;
    if (scc_i4 !== 1'b1) begin tests_failed++; $display("FAIL ena_on_write: got %b want 1", scc_i4); end
    SCC_I_ENA = 1'b0;
    @(posedge CLK); #1;
    SCC_I_ENA = 1'b1;
    m_mode = 6'h00;
    tests_run++;
    if (scc_i4 !== 1'b0) begin tests_failed++; $display("FAIL ena_drop_clears: got %b want 0", scc_i4); end
  endtask

  task automatic test_back_to_back();
    bus_write(16'h5000, 8'h21, 1);
    bus_write(16'h7000, 8'h22, 1);
    tests_run++;
    if (bank4[15:0] !== 16'h2221) begin tests_failed++; $display("FAIL b2b_writes: got %h want 2221", bank4[15:0]); end
    @(posedge CLK); #1;
    bus4.SLTSL_n = 1'b0; bus4.ADDR = 16'h9000; bus4.DIN = 8'h11; bus4.WR_n = 1'b0;
    repeat (4) @(posedge CLK);
    #1 bus4.DIN = 8'h12;
    repeat (6) @(posedge CLK);
    #1 bus4.WR_n = 1'b1; bus4.SLTSL_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1 model_write(16'h9000, 8'h11);
    tests_run++;
    if (bank4[23:16] !== 8'h11) begin tests_failed++; $display("FAIL held_write: got %h want 11", bank4[23:16]); end
    bus4.ADDR = 16'hB000; bus4.DIN = 8'h5A; bus4.WR_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1 bus4.WR_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if (bank4[31:24] !== m_bank[3]) begin tests_failed++; $display("FAIL slot_ignore: got %h want %h", bank4[31:24], m_bank[3]); end
  endtask

  task automatic test_bus_reset();
    @(posedge CLK); #1;
    bus4.SLTSL_n = 1'b0; bus4.ADDR = 16'h7000; bus4.DIN = 8'h33; bus4.WR_n = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    tests_run++;
    if (bank4[15:8] !== 8'h33) begin tests_failed++; $display("FAIL pre_reset_write: got %h want 33", bank4[15:8]); end
    BUS_RESET_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if ({win4, map4} !== 22'h0) begin tests_failed++; $display("FAIL srst_outputs: got %h want 0", {win4, map4}); end
    BUS_RESET_n = 1'b1;
    repeat (4) @(posedge CLK);
    #1 bus4.WR_n = 1'b1; bus4.SLTSL_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1 model_reset();
    tests_run++;
    if (bank4 !== 32'h03020100) begin tests_failed++; $display("FAIL srst_bank4: got %h want 03020100", bank4); end
    tests_run++;
    if (bank8 !== 64'h0706050403020100) begin tests_failed++; $display("FAIL srst_bank8: got %h want 0706050403020100", bank8); end
  endtask

  task automatic test_readback();
    bus_write(16'hD000, 8'h55, 2);
    tests_run++;
    if (bank8[39:32] !== 8'h55) begin tests_failed++; $display("FAIL bank4_of_8: got %h want 55", bank8[39:32]); end
    tests_run++;
    if (bank4 !== 32'h03020100) begin tests_failed++; $display("FAIL d000_no_hit4: got %h want 03020100", bank4); end
    @(posedge CLK); #1;
    bus4.SLTSL_n = 1'b0; bus4.ADDR = 16'hD000; bus4.RD_n = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (bus8.BUSDIR_n !== 1'b1) begin tests_failed++; $display("FAIL rd_latency: got %b want 1", bus8.BUSDIR_n); end
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      tests_run++;
`ifdef MEGAROM_MAPPER_READBACK_EN
      if ({bus8.BUSDIR_n, bus8.DOUT, bus4.BUSDIR_n} !== {1'b0, 8'h55, 1'b1}) begin
        tests_failed++; $display("FAIL readback cyc%0d: got %b_%h_%b want 0_55_1", c, bus8.BUSDIR_n, bus8.DOUT, bus4.BUSDIR_n);
      end
`else
      if ({bus8.BUSDIR_n, bus8.DOUT, bus4.BUSDIR_n} !== {1'b1, 8'h00, 1'b1}) begin
        tests_failed++; $display("FAIL no_readback cyc%0d: got %b_%h_%b want 1_00_1", c, bus8.BUSDIR_n, bus8.DOUT, bus4.BUSDIR_n);
      end
`endif
    end
    bus4.RD_n = 1'b1; bus4.SLTSL_n = 1'b1;
    @(posedge CLK); #1;
    tests_run++;
    if ({bus8.BUSDIR_n, bus8.DOUT} !== 9'h100) begin tests_failed++; $display("FAIL rd_release: got %h want 100", {bus8.BUSDIR_n, bus8.DOUT}); end
  endtask

  initial begin
    test_reset();
    test_sound_select();
    test_lock();
    test_partial_lock();
    test_scc_enable();
    test_back_to_back();
    test_bus_reset();
    test_readback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
